fifo36_realign: RTL and testbench
=================================

Name: fifo36_realign

Overview:
- Streaming realigner for 36-bit line-framed streams. Strips DROP_BYTES leading bytes from every frame and repacks the remaining bytes into full 32-bit lines.
- Typical use: removing the 2-byte pad on Ethernet RX so IP headers land 32-bit aligned.
- Supersedes the fixed 2-byte realigner:
  - Byte count is configurable.
  - Single-line and runt frames are handled.
  - A per-frame bypass mode is added.
  - The block resynchronises after clear or a stray mid-frame line.
- Sits between MAC RX FIFO and packet router.

Parameters:
- DROP_BYTES, 2: leading bytes removed per frame, legal 0..3. 0 = pure pass-through.
- CNT_W, 16: width of runt_count.

Ports:
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush. Same effect as reset on all state, counter excluded.
- bypass  in  1  frame passes unmodified. Sampled only on an accepted sof line in IDLE.
- datain  in  36  {occ[1:0], eof, sof, data[31:0]}. Byte 0 is at [31:24].
- src_rdy_i  in  1  datain valid.
- dst_rdy_o  out  1  block accepts datain.
- dataout  out  36  same format as datain.
- src_rdy_o  out  1  dataout valid.
- dst_rdy_i  in  1  downstream accepts dataout.
- runt_count  out  CNT_W  frames discarded because length ≤ DROP_BYTES. Wraps.

Behaviour:
- Encoding:
  - occ: 0 = 4 valid bytes, 1..3 = that many. occ is meaningful only on eof lines.
  - Let N = DROP_BYTES. Let v(x) = valid bytes of a line (occ==0 ? 4 : occ).
  - Output occ = count[1:0].
- Transfers: xfer_in = src_rdy_i & dst_rdy_o; xfer_out = src_rdy_o & dst_rdy_i.
- Combinational output path. No lines are added beyond the single held line, so per-frame latency is at most one input line.
- Registers:
  - hold[31:0], hold_v[2:0], state.
  - Reset values: state=IDLE, hold=0, hold_v=0, runt_count=0.
  - Outputs at reset: src_rdy_o=0, dataout=0.
- IDLE:
  - Non-sof lines: accepted and discarded (dst_rdy_o=1, src_rdy_o=0). This is the resync behaviour.
  - sof line with bypass=1, or N==0: passed through unchanged. Flow control is straight-through (dst_rdy_o=dst_rdy_i, src_rdy_o=src_rdy_i). Go to PASS, or stay in IDLE if eof.
  - sof & !eof: accepted without waiting for dst_rdy_i. Line stored in hold. Go to HELD.
  - sof & eof, v>N: emit one line {data<<8N}, sof=eof=1, count v−N. Consumed only on xfer_out. Stay IDLE.
  - sof & eof, v≤N: accepted without output. runt_count+1. Stay IDLE.
- HELD (dst_rdy_o=dst_rdy_i, src_rdy_o=src_rdy_i):
  - Output data = {hold[8(4−N)−1:0], datain[31:32−8N]}.
  - sof flag = first output of the frame (tracked by a first_out bit set on entry from IDLE).
  - Non-eof line: output count 4. hold ← datain.
  - eof line, v≤N: output eof=1, count (4−N)+v. Go to IDLE.
  - eof line, v>N: output full line, not eof. hold ← datain, hold_v ← v. Go to FLUSH.
  - sof seen while in HELD: flag ignored, line treated as data.
- FLUSH (dst_rdy_o=0, src_rdy_o=1):
  - Emit {hold<<8N}, eof=1, count hold_v−N, sof=first_out.
  - On xfer_out go to IDLE.
- PASS:
  - Straight pass-through until the eof line transfers, then go to IDLE.
  - bypass changes mid-frame are ignored.
- No combinational path from dst_rdy_i to src_rdy_o. The path from src_rdy_i/dst_rdy_i to outputs is allowed.
- clear or reset mid-frame:
  - Partial frame is abandoned. No eof is generated for it.
  - Any input tail is discarded by IDLE resync.
  - clear does not reset runt_count. reset_n does.
- Simultaneous clear and xfer: clear wins. The line is dropped.
- runt_count wraps at 2^CNT_W.

Decomposition:
- Shared package fifo36_pkg holds:
  - Field positions: OCC_HI=35, OCC_LO=34, EOF_BIT=33, SOF_BIT=32.
  - Functions occ2cnt and cnt2occ.
  - State localparams IDLE/HELD/FLUSH/PASS.
- One natural sub-module: fifo36_byte_shift. Combinational merge of hold and datain by N bytes, with valid-count output.

Test Plan:
- N=2. 10-byte frame, lines AABBCCDD / EEFF0011 / 2233xxxx (occ 2) -> out CCDDEEFF (sof) then 00112233 (eof, occ 0). runt_count=0.
- N=2. 11-byte frame, last line 223344xx (occ 3) -> out CCDDEEFF, 00112233, then FLUSH line 44xxxxxx (eof, occ 1). dst_rdy_o=0 during FLUSH.
- N=3. Single-line frame 11223344 (sof, eof, occ 0) -> one line 44xxxxxx, sof=eof=1, occ 1. Single-line frame with occ 3 -> no output, runt_count=1.
- bypass=1 at sof of a 3-line frame -> output identical to input. bypass toggled to 0 mid-frame has no effect. Next frame is realigned.
- Random dst_rdy_i and src_rdy_i throttling (50%) over 1000 random frames of length 1..64 -> byte stream matches model. Every frame's first output line has sof, last has eof. No data lost or duplicated.
- Assert clear in HELD mid-frame, then feed remaining two non-sof lines and a new frame -> orphan lines discarded without output. New frame realigned correctly. runt_count unchanged.

Source files
------------

// File: rtl/fifo36_pkg.sv
// Shared definitions for the 36-bit line-framed stream blocks.
// Line format: {occ[1:0], eof, sof, data[31:0]}, byte 0 at data[31:24].
package fifo36_pkg;

  localparam int unsigned OCC_HI  = 35;
  localparam int unsigned OCC_LO  = 34;
  localparam int unsigned EOF_BIT = 33;
  localparam int unsigned SOF_BIT = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HELD  = 2'd1,
    FLUSH = 2'd2,
    PASS  = 2'd3
  } state_e;

  // occ encodes 4 valid bytes as 0
  function automatic logic [2:0] occ2cnt(input logic [1:0] occ);
    return (occ == 2'd0) ? 3'd4 : {1'b0, occ};
  endfunction

  function automatic logic [1:0] cnt2occ(input logic [2:0] cnt);
    return (cnt == 3'd4) ? 2'd0 : cnt[1:0];
  endfunction

endpackage

// File: rtl/fifo36_byte_shift.sv
// Byte merge for the realigner: concatenates a high and a low word, drops
// DROP_BYTES leading bytes and returns the top 32 bits plus the resulting
// valid-byte count (saturated at one full line).
// Ports:
//   hi_i, hi_v_i  - older word and its valid byte count
//   lo_i, lo_v_i  - newer word and its valid byte count
//   data_o        - merged line
//   cnt_o         - valid bytes in data_o (1..4)
module fifo36_byte_shift #(
  parameter int unsigned DROP_BYTES = 2
) (
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic [2:0]  hi_v_i,
  input  logic [2:0]  lo_v_i,
  output logic [31:0] data_o,
  output logic [2:0]  cnt_o
);

  logic [3:0] sum;

  assign data_o = 32'(({hi_i, lo_i} << (8 * DROP_BYTES)) >> 32);
  assign sum    = {1'b0, hi_v_i} + {1'b0, lo_v_i} - 4'(DROP_BYTES);
  assign cnt_o  = (sum > 4'd4) ? 3'd4 : sum[2:0];

endmodule

// File: rtl/fifo36_realign.sv
// Streaming realigner: strips DROP_BYTES leading bytes from every frame and
// repacks the rest into full 32-bit lines. Per-frame bypass, runt discard,
// resync on stray mid-frame lines.
// Ports:
//   clk, reset_n          - clock, async active-low reset
//   clear                 - synchronous flush (runt_count kept)
//   bypass                - pass frame unmodified, sampled on sof in IDLE
//   datain/src_rdy_i/dst_rdy_o   - input stream
//   dataout/src_rdy_o/dst_rdy_i  - output stream
//   runt_count            - frames discarded for length <= DROP_BYTES
module fifo36_realign #(
  parameter int unsigned DROP_BYTES = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             bypass,
  input  logic [35:0]      datain,
  input  logic             src_rdy_i,
  output logic             dst_rdy_o,
  output logic [35:0]      dataout,
  output logic             src_rdy_o,
  input  logic             dst_rdy_i,
  output logic [CNT_W-1:0] runt_count
);
  import fifo36_pkg::*;

  localparam logic [2:0] NDrop      = 3'(DROP_BYTES);
  localparam bit         AlwaysPass = (DROP_BYTES == 0);

  state_e           state_q, state_d;
  logic [31:0]      hold_q, hold_d;
  logic [2:0]       hold_v_q, hold_v_d;
  logic             first_q, first_d;
  logic [CNT_W-1:0] runt_q, runt_d;

  logic        in_sof, in_eof;
  logic [2:0]  in_v;
  logic [31:0] sh_hi, sh_lo, sh_data;
  logic [2:0]  sh_hi_v, sh_lo_v, sh_cnt;
  logic        use_pass, out_sof, out_eof, src_rdy;
  logic        hs_in;

  assign in_sof = datain[SOF_BIT];
  assign in_eof = datain[EOF_BIT];
  assign in_v   = occ2cnt(datain[OCC_HI:OCC_LO]);
  // Handshake when both sides ready; used where flow control is straight-through
  assign hs_in  = src_rdy_i & dst_rdy_i;

  fifo36_byte_shift #(
    .DROP_BYTES(DROP_BYTES)
  ) u_shift (
    .hi_i   (sh_hi),
    .lo_i   (sh_lo),
    .hi_v_i (sh_hi_v),
    .lo_v_i (sh_lo_v),
    .data_o (sh_data),
    .cnt_o  (sh_cnt)
  );

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    hold_v_d  = hold_v_q;
    first_d   = first_q;
    runt_d    = runt_q;
    dst_rdy_o = 1'b0;
    src_rdy   = 1'b0;
    use_pass  = 1'b0;
    out_sof   = 1'b0;
    out_eof   = 1'b0;
    sh_hi     = hold_q;
    sh_lo     = '0;
    sh_hi_v   = 3'd4;
    sh_lo_v   = 3'd0;

    unique case (state_q)
      IDLE: begin
        if (!in_sof) begin
          dst_rdy_o = 1'b1;  // resync: discard anything outside a frame
        end else if (bypass || AlwaysPass) begin
          use_pass  = 1'b1;
          dst_rdy_o = dst_rdy_i;
          src_rdy   = src_rdy_i;
          if (hs_in && !in_eof) state_d = PASS;
        end else if (!in_eof) begin
          dst_rdy_o = 1'b1;
          if (src_rdy_i) begin
            hold_d   = datain[31:0];
            hold_v_d = 3'd4;
            first_d  = 1'b1;
            state_d  = HELD;
          end
        end else if (in_v > NDrop) begin
          sh_hi     = datain[31:0];
          sh_hi_v   = in_v;
          out_sof   = 1'b1;
          out_eof   = 1'b1;
          dst_rdy_o = dst_rdy_i;
          src_rdy   = src_rdy_i;
        end else begin
          dst_rdy_o = 1'b1;
          if (src_rdy_i) runt_d = runt_q + 1'b1;
        end
      end
      HELD: begin
        sh_lo     = datain[31:0];
        sh_lo_v   = in_eof ? in_v : 3'd4;
        out_sof   = first_q;
        out_eof   = in_eof && (in_v <= NDrop);
        dst_rdy_o = dst_rdy_i;
        src_rdy   = src_rdy_i;
        if (hs_in) begin
          first_d = 1'b0;
          if (in_eof && (in_v <= NDrop)) begin
            state_d = IDLE;
          end else begin
            hold_d = datain[31:0];
            if (in_eof) begin
              // Tail bytes do not fit in this line; emit them next cycle
              hold_v_d = in_v;
              state_d  = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        sh_hi_v = hold_v_q;
        out_sof = first_q;
        out_eof = 1'b1;
        src_rdy = 1'b1;
        if (dst_rdy_i) state_d = IDLE;
      end
      PASS: begin
        use_pass  = 1'b1;
        dst_rdy_o = dst_rdy_i;
        src_rdy   = src_rdy_i;
        if (hs_in && in_eof) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Flush wins over any concurrent transfer; the line is dropped
    if (clear) begin
      state_d  = IDLE;
      hold_d   = '0;
      hold_v_d = '0;
      first_d  = 1'b0;
      runt_d   = runt_q;
    end
  end

  always_comb begin
    dataout = '0;
    if (src_rdy) begin
      dataout = use_pass ? datain : {cnt2occ(sh_cnt), out_eof, out_sof, sh_data};
    end
  end

  assign src_rdy_o  = src_rdy;
  assign runt_count = runt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      hold_v_q <= '0;
      first_q  <= 1'b0;
      runt_q   <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
      first_q  <= first_d;
      runt_q   <= runt_d;
    end
  end

endmodule

// File: tb/tb_fifo36_realign.sv
// Bench for fifo36_realign: two instances (DROP_BYTES 2 and 3) share the
// stimulus, one selected at a time. Expected output lines come from a
// byte-queue frame model; observed transfers are collected on the falling edge.
module tb_fifo36_realign;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic        bypass = 1'b0;
  logic [35:0] datain = '0;
  logic        src_rdy_i = 1'b0;
  logic        dst_rdy_i = 1'b0;
  logic        sel = 1'b0;

  logic        src2, src3;
  logic        dst_rdy_o2, dst_rdy_o3, src_rdy_o2, src_rdy_o3;
  logic [35:0] dataout2, dataout3;
  logic [15:0] runt2, runt3;

  int checks = 0;
  int errors = 0;
  int runt_exp [2];
  logic [35:0] obs[$];
  logic [35:0] exp_q[$];
  logic [35:0] msk_q[$];

  assign src2 = src_rdy_i & ~sel;
  assign src3 = src_rdy_i & sel;

  always #5 clk = ~clk;

  fifo36_realign #(.DROP_BYTES(2), .CNT_W(16)) dut2 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .bypass(bypass), .datain(datain),
    .src_rdy_i(src2), .dst_rdy_o(dst_rdy_o2), .dataout(dataout2), .src_rdy_o(src_rdy_o2),
    .dst_rdy_i(dst_rdy_i), .runt_count(runt2)
  );

  fifo36_realign #(.DROP_BYTES(3), .CNT_W(16)) dut3 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .bypass(bypass), .datain(datain),
    .src_rdy_i(src3), .dst_rdy_o(dst_rdy_o3), .dataout(dataout3), .src_rdy_o(src_rdy_o3),
    .dst_rdy_i(dst_rdy_i), .runt_count(runt3)
  );

  // Output transfer seen here completes at the next rising edge
  always @(negedge clk) begin
    if (reset_n && !clear) begin
      if (!sel && src_rdy_o2 && dst_rdy_i) obs.push_back(dataout2);
      if (sel && src_rdy_o3 && dst_rdy_i) obs.push_back(dataout3);
    end
  end

  task automatic check36(input string tag, input logic [35:0] obs_v, input logic [35:0] exp_v);
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs_v, exp_v);
    end
  endtask

  task automatic check_int(input string tag, input int obs_v, input int exp_v);
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs_v, exp_v);
    end
  endtask

  task automatic drive_line(input logic [35:0] line, input bit thr, input logic byp);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    datain = line;
    bypass = byp;
    while (!acc && n < 500) begin
      src_rdy_i = thr ? 1'($urandom_range(0, 1)) : 1'b1;
      dst_rdy_i = thr ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      acc = src_rdy_i && (sel ? dst_rdy_o3 : dst_rdy_o2);
      @(posedge clk);
      #1;
      n++;
    end
    src_rdy_i = 1'b0;
    if (!acc) check_int("accept_timeout", int'(acc), 1);
  endtask

  // Builds input lines for a frame, records the expected output, then drives it
  task automatic send_frame(input logic [7:0] b[$], input bit byp, input bit thr);
    logic [35:0] lines[$];
    logic [35:0] w, m;
    int len, nl, nd, l_out, no, idx;
    len = b.size();
    nl = (len + 3) / 4;
    nd = sel ? 3 : 2;
    for (int k = 0; k < nl; k++) begin
      w = '0;
      for (int i = 0; i < 4; i++) w[31-8*i -: 8] = (4*k+i < len) ? b[4*k+i] : 8'($urandom);
      w[32] = (k == 0);
      w[33] = (k == nl - 1);
      w[35:34] = (k == nl - 1) ? 2'(len % 4) : 2'b00;
      lines.push_back(w);
    end
    if (byp) begin
      foreach (lines[k]) begin
        exp_q.push_back(lines[k]);
        msk_q.push_back({36{1'b1}});
      end
    end else if (len <= nd) begin
      runt_exp[int'(sel)]++;
    end else begin
      l_out = len - nd;
      no = (l_out + 3) / 4;
      for (int j = 0; j < no; j++) begin
        w = '0;
        m = 36'hF_0000_0000;
        for (int i = 0; i < 4; i++) begin
          idx = nd + 4*j + i;
          if (idx < len) begin
            w[31-8*i -: 8] = b[idx];
            m[31-8*i -: 8] = 8'hFF;
          end
        end
        w[32] = (j == 0);
        w[33] = (j == no - 1);
        w[35:34] = (j == no - 1) ? 2'(l_out % 4) : 2'b00;
        exp_q.push_back(w);
        msk_q.push_back(m);
      end
    end
    for (int k = 0; k < nl; k++) begin
      drive_line(lines[k], thr, (k == 0) ? logic'(byp) : 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic drain(input string tag);
    int n;
    logic [35:0] o, e, m;
    n = 0;
    src_rdy_i = 1'b0;
    dst_rdy_i = 1'b1;
    while (obs.size() < exp_q.size() && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check_int({tag, "_lines"}, obs.size(), exp_q.size());
    while (obs.size() > 0 && exp_q.size() > 0) begin
      o = obs.pop_front();
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      check36({tag, "_data"}, o & m, e & m);
    end
    obs.delete();
    exp_q.delete();
    msk_q.delete();
    check_int({tag, "_runt"}, int'(sel ? runt3 : runt2), runt_exp[int'(sel)] % 65536);
  endtask

  task automatic rand_frames(input int count, input string tag);
    logic [7:0] b[$];
    int len;
    for (int f = 0; f < count; f++) begin
      b.delete();
      len = $urandom_range(1, 64);
      for (int i = 0; i < len; i++) b.push_back(8'($urandom));
      send_frame(b, ($urandom_range(0, 7) == 0), 1'b1);
    end
    drain(tag);
  endtask

  initial begin
    logic [7:0] b[$];
    logic [35:0] o0, o1;
    int r_before;
    runt_exp[0] = 0;
    runt_exp[1] = 0;

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check36("rst_dataout", dataout2, 36'h0);
    check_int("rst_src_rdy", int'(src_rdy_o2), 0);
    check_int("rst_runt", int'(runt2), 0);
    check36("rst_dataout3", dataout3, 36'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check_int("idle_dst_rdy", int'(dst_rdy_o2), 1);
    @(posedge clk);
    #1;

    // 10-byte frame, N=2
    b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h00, 8'h11, 8'h22, 8'h33};
    send_frame(b, 1'b0, 1'b0);
    o0 = (obs.size() > 0) ? obs[0] : 'x;
    o1 = (obs.size() > 1) ? obs[1] : 'x;
    check36("t1_line0", o0, 36'h1_CCDD_EEFF);
    check36("t1_line1", o1, 36'h2_0011_2233);
    drain("t1");

    // 11-byte frame, N=2: tail emitted by FLUSH with input stalled
    b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(b, 1'b0, 1'b0);
    dst_rdy_i = 1'b0;
    @(negedge clk);
    check_int("t2_flush_dst_rdy", int'(dst_rdy_o2), 0);
    check_int("t2_flush_src_rdy", int'(src_rdy_o2), 1);
    check36("t2_flush_top", {24'h0, dataout2[35:24]}, 36'h644);
    @(posedge clk);
    #1;
    drain("t2");

    // bypass frame, bypass dropped mid-frame, then a realigned frame
    b.delete();
    for (int i = 0; i < 12; i++) b.push_back(8'($urandom));
    send_frame(b, 1'b1, 1'b0);
    b.delete();
    for (int i = 0; i < 9; i++) b.push_back(8'($urandom));
    send_frame(b, 1'b0, 1'b0);
    drain("t4");

    // clear in HELD, orphan tail, new frame
    r_before = int'(runt2);
    drive_line(36'h1_AABB_CCDD, 1'b0, 1'b0);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    drive_line(36'h0_EEFF_0011, 1'b0, 1'b0);
    drive_line(36'h2_2233_4455, 1'b0, 1'b0);
    b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    send_frame(b, 1'b0, 1'b0);
    drain("t6");
    check_int("t6_runt_kept", int'(runt2), r_before);

    rand_frames(700, "rand2");

    // N=3 instance
    sel = 1'b1;
    @(posedge clk);
    #1;
    b = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(b, 1'b0, 1'b0);
    o0 = (obs.size() > 0) ? obs[0] : 'x;
    check36("t3_single_top", {24'h0, o0[35:24]}, 36'h744);
    b = '{8'h55, 8'h66, 8'h77};
    send_frame(b, 1'b0, 1'b0);
    drain("t3");
    check_int("t3_runt", int'(runt3), 1);

    rand_frames(300, "rand3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
